// File: rtl/datapath_pkg.sv
// Shared widths, ALU opcodes and bus-source priority encoding for the phase-1 SRC datapath.
// Optional mul/div support is selected by DATAPATH_MULDIV_EN (see alu.sv).
package datapath_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned OP_W  = 5;

    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OP_W-1:0] OP_SHR  = 5'b00111;
    localparam logic [OP_W-1:0] OP_SHRA = 5'b01000;
    localparam logic [OP_W-1:0] OP_SHL  = 5'b01001;
    localparam logic [OP_W-1:0] OP_ROR  = 5'b01010;
    localparam logic [OP_W-1:0] OP_ROL  = 5'b01011;
    localparam logic [OP_W-1:0] OP_MUL  = 5'b01111;
    localparam logic [OP_W-1:0] OP_DIV  = 5'b10000;
    localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
    localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_R0,
        SEL_R1,
        SEL_PC,
        SEL_ZLOW,
        SEL_MDR
    } bus_sel_e;

    // Highest-priority active driver wins: MDR > Zlow > PC > R1 > R0.
    function automatic bus_sel_e bus_sel_f(input logic mdr_out, input logic zlow_out,
                                           input logic pc_out, input logic r1_out,
                                           input logic r0_out);
        bus_sel_e sel;
        sel = SEL_NONE;
        if (mdr_out)       sel = SEL_MDR;
        else if (zlow_out) sel = SEL_ZLOW;
        else if (pc_out)   sel = SEL_PC;
        else if (r1_out)   sel = SEL_R1;
        else if (r0_out)   sel = SEL_R0;
        return sel;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: A = Y, B = bus, 2*W-bit result feeding Z.
// Signed mul/div exist only when DATAPATH_MULDIV_EN is defined; otherwise those opcodes increment B.
module alu
    import datapath_pkg::*;
#(
    parameter int unsigned W = WIDTH
) (
    input  logic [W-1:0]    a_i,
    input  logic [W-1:0]    b_i,
    input  logic [OP_W-1:0] op_i,
    output logic [2*W-1:0]  result_c
);

    localparam int unsigned SH_W = $clog2(W);

    logic [SH_W-1:0] amt;
    logic [2*W-1:0]  dbl;
    logic [2*W-1:0]  ror_full;
    logic [2*W-1:0]  rol_full;
    logic [W-1:0]    lo;
    logic [W-1:0]    hi;

    assign amt      = b_i[SH_W-1:0];
    // Rotates come from shifting a doubled copy of A.
    assign dbl      = {a_i, a_i};
    assign ror_full = dbl >> amt;
    assign rol_full = dbl << amt;

`ifdef DATAPATH_MULDIV_EN
    logic [2*W-1:0]        prod;
    logic signed [W-1:0]   sa;
    logic signed [W-1:0]   sb;
    logic signed [W-1:0]   quo;
    logic signed [W-1:0]   rem;

    assign prod = {{W{a_i[W-1]}}, a_i} * {{W{b_i[W-1]}}, b_i};
    assign sa   = a_i;
    assign sb   = b_i;
    assign quo  = (b_i == '0) ? '1  : sa / sb;
    assign rem  = (b_i == '0) ? sa  : sa % sb;
`endif

    always_comb begin
        lo = b_i + W'(1);
        hi = '0;
        unique case (op_i)
            OP_ADD:  lo = a_i + b_i;
            OP_SUB:  lo = a_i - b_i;
            OP_AND:  lo = a_i & b_i;
            OP_OR:   lo = a_i | b_i;
            OP_SHR:  lo = a_i >> amt;
            OP_SHRA: lo = $signed(a_i) >>> amt;
            OP_SHL:  lo = a_i << amt;
            OP_ROR:  lo = ror_full[W-1:0];
            OP_ROL:  lo = rol_full[2*W-1:W];
`ifdef DATAPATH_MULDIV_EN
            OP_MUL: begin
                lo = prod[W-1:0];
                hi = prod[2*W-1:W];
            end
            OP_DIV: begin
                lo = quo;
                hi = rem;
            end
`endif
            OP_NEG:  lo = W'(0) - b_i;
            OP_NOT:  lo = ~b_i;
            default: lo = b_i + W'(1);
        endcase
        result_c = {hi, lo};
    end

endmodule

// File: rtl/datapath.sv
// Phase-1 SRC datapath: shared bus, R0/R1/PC/IR/MAR/MDR/Y registers and 64-bit Z fed by the ALU.
// Build with DATAPATH_MULDIV_EN to include signed multiply/divide in the ALU.
module datapath
    import datapath_pkg::*;
(
    input  logic               clk,
    input  logic               clr,
    input  logic               R0_in,
    input  logic               R1_in,
    input  logic               PC_in,
    input  logic               IR_in,
    input  logic               Y_in,
    input  logic               Z_in,
    input  logic               MAR_in,
    input  logic               MDR_in,
    input  logic               Read,
    input  logic               R0_out,
    input  logic               R1_out,
    input  logic               PC_out,
    input  logic               Zlow_out,
    input  logic               MDR_out,
    input  logic [OP_W-1:0]    alu_instruction,
    input  logic [WIDTH-1:0]   Mdatain,
    output logic [WIDTH-1:0]   Bus_Data,
    output logic [WIDTH-1:0]   R0_Data,
    output logic [WIDTH-1:0]   R1_Data,
    output logic [WIDTH-1:0]   PC_Data,
    output logic [WIDTH-1:0]   IR_Data,
    output logic [WIDTH-1:0]   MAR_Data,
    output logic [WIDTH-1:0]   MDR_Data,
    output logic [WIDTH-1:0]   Y_Data,
    output logic [WIDTH-1:0]   Zhigh_Data,
    output logic [WIDTH-1:0]   Zlow_Data
);

    logic [WIDTH-1:0]   r0_q,  r0_d;
    logic [WIDTH-1:0]   r1_q,  r1_d;
    logic [WIDTH-1:0]   pc_q,  pc_d;
    logic [WIDTH-1:0]   ir_q,  ir_d;
    logic [WIDTH-1:0]   mar_q, mar_d;
    logic [WIDTH-1:0]   mdr_q, mdr_d;
    logic [WIDTH-1:0]   y_q,   y_d;
    logic [2*WIDTH-1:0] z_q,   z_d;
    logic [2*WIDTH-1:0] alu_result;
    logic [WIDTH-1:0]   bus;
    bus_sel_e           sel;

    assign sel = bus_sel_f(MDR_out, Zlow_out, PC_out, R1_out, R0_out);

    // Bus mux; Z reaches the bus only through its register, so there is no loop through the ALU.
    always_comb begin
        bus = '0;
        unique case (sel)
            SEL_MDR:  bus = mdr_q;
            SEL_ZLOW: bus = z_q[WIDTH-1:0];
            SEL_PC:   bus = pc_q;
            SEL_R1:   bus = r1_q;
            SEL_R0:   bus = r0_q;
            default:  bus = '0;
        endcase
    end

    alu #(.W(WIDTH)) u_alu (
        .a_i      (y_q),
        .b_i      (bus),
        .op_i     (alu_instruction),
        .result_c (alu_result)
    );

    always_comb begin
        r0_d  = R0_in  ? bus : r0_q;
        r1_d  = R1_in  ? bus : r1_q;
        pc_d  = PC_in  ? bus : pc_q;
        ir_d  = IR_in  ? bus : ir_q;
        mar_d = MAR_in ? bus : mar_q;
        y_d   = Y_in   ? bus : y_q;
        z_d   = Z_in   ? alu_result : z_q;
        mdr_d = mdr_q;
        if (MDR_in) mdr_d = Read ? Mdatain : bus;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r0_q  <= '0;
            r1_q  <= '0;
            pc_q  <= '0;
            ir_q  <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            y_q   <= '0;
            z_q   <= '0;
        end else begin
            r0_q  <= r0_d;
            r1_q  <= r1_d;
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            mar_q <= mar_d;
            mdr_q <= mdr_d;
            y_q   <= y_d;
            z_q   <= z_d;
        end
    end

    assign Bus_Data   = bus;
    assign R0_Data    = r0_q;
    assign R1_Data    = r1_q;
    assign PC_Data    = pc_q;
    assign IR_Data    = ir_q;
    assign MAR_Data   = mar_q;
    assign MDR_Data   = mdr_q;
    assign Y_Data     = y_q;
    assign Zhigh_Data = z_q[2*WIDTH-1:WIDTH];
    assign Zlow_Data  = z_q[WIDTH-1:0];

endmodule

// File: tb/tb_datapath.sv
// Directed and randomized checks of the SRC datapath against an arithmetic reference model.
module tb_datapath;

    logic        clk = 1'b0;
    logic        clr;
    logic        R0_in, R1_in, PC_in, IR_in, Y_in, Z_in, MAR_in, MDR_in, Read;
    logic        R0_out, R1_out, PC_out, Zlow_out, MDR_out;
    logic [4:0]  alu_instruction;
    logic [31:0] Mdatain;
    logic [31:0] Bus_Data, R0_Data, R1_Data, PC_Data, IR_Data, MAR_Data, MDR_Data, Y_Data;
    logic [31:0] Zhigh_Data, Zlow_Data;

    int total = 0;
    int bad   = 0;

    datapath dut (
        .clk(clk), .clr(clr),
        .R0_in(R0_in), .R1_in(R1_in), .PC_in(PC_in), .IR_in(IR_in), .Y_in(Y_in),
        .Z_in(Z_in), .MAR_in(MAR_in), .MDR_in(MDR_in), .Read(Read),
        .R0_out(R0_out), .R1_out(R1_out), .PC_out(PC_out), .Zlow_out(Zlow_out),
        .MDR_out(MDR_out), .alu_instruction(alu_instruction), .Mdatain(Mdatain),
        .Bus_Data(Bus_Data), .R0_Data(R0_Data), .R1_Data(R1_Data), .PC_Data(PC_Data),
        .IR_Data(IR_Data), .MAR_Data(MAR_Data), .MDR_Data(MDR_Data), .Y_Data(Y_Data),
        .Zhigh_Data(Zhigh_Data), .Zlow_Data(Zlow_Data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic all_off();
        {R0_in, R1_in, PC_in, IR_in, Y_in, Z_in, MAR_in, MDR_in, Read} = '0;
        {R0_out, R1_out, PC_out, Zlow_out, MDR_out} = '0;
        alu_instruction = '0;
        Mdatain = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        all_off();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_r0"},  {32'h0, R0_Data},  64'h0);
        check({tag, "_r1"},  {32'h0, R1_Data},  64'h0);
        check({tag, "_pc"},  {32'h0, PC_Data},  64'h0);
        check({tag, "_ir"},  {32'h0, IR_Data},  64'h0);
        check({tag, "_mar"}, {32'h0, MAR_Data}, 64'h0);
        check({tag, "_mdr"}, {32'h0, MDR_Data}, 64'h0);
        check({tag, "_y"},   {32'h0, Y_Data},   64'h0);
        check({tag, "_z"},   {Zhigh_Data, Zlow_Data}, 64'h0);
    endtask

    // Memory word into MDR, then MDR onto the bus into Y.
    task automatic load_y(input logic [31:0] v);
        Mdatain = v; Read = 1'b1; MDR_in = 1'b1;
        tick();
        MDR_out = 1'b1; Y_in = 1'b1;
        tick();
    endtask

    // Put b in MDR and run one ALU op with B taken from MDR on the bus.
    task automatic alu_mdr(input logic [4:0] op, input logic [31:0] b);
        Mdatain = b; Read = 1'b1; MDR_in = 1'b1;
        tick();
        MDR_out = 1'b1; Z_in = 1'b1; alu_instruction = op;
        tick();
    endtask

    // Reference ALU: Z = {hi, lo} written from the opcode table with plain arithmetic.
    function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] lo;
        int          n;
        longint      p;
        int          sa, sb;
        n  = int'(b % 32);
        lo = a;
        case (op)
            5'd3:  return {32'h0, a + b};
            5'd4:  return {32'h0, a - b};
            5'd5:  return {32'h0, a & b};
            5'd6:  return {32'h0, a | b};
            5'd7:  begin for (int i = 0; i < n; i++) lo = {1'b0, lo[31:1]};  return {32'h0, lo}; end
            5'd8:  begin for (int i = 0; i < n; i++) lo = {lo[31], lo[31:1]}; return {32'h0, lo}; end
            5'd9:  begin for (int i = 0; i < n; i++) lo = lo * 2;              return {32'h0, lo}; end
            5'd10: begin for (int i = 0; i < n; i++) lo = {lo[0], lo[31:1]};   return {32'h0, lo}; end
            5'd11: begin for (int i = 0; i < n; i++) lo = {lo[30:0], lo[31]};  return {32'h0, lo}; end
`ifdef DATAPATH_MULDIV_EN
            5'd15: begin
                sa = a; sb = b;
                p  = longint'(sa) * longint'(sb);
                return 64'(p);
            end
            5'd16: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                sa = a; sb = b;
                return {32'(sa % sb), 32'(sa / sb)};
            end
`endif
            5'd17: return {32'h0, 32'h0 - b};
            5'd18: return {32'h0, ~b};
            default: return {32'h0, b + 32'h1};
        endcase
    endfunction

    initial begin
        logic [31:0] ir_v;
        logic [31:0] a, b;
        logic [4:0]  op;

        all_off();
        clr = 1'b0;
        #2;
        check_all_zero("por");
        @(negedge clk);
        clr = 1'b1;
        #1;

        // MDR load from memory, then MDR -> R0 over the bus.
        Mdatain = 32'h1234; Read = 1'b1; MDR_in = 1'b1;
        tick();
        check("mdr_load", {32'h0, MDR_Data}, 64'h1234);
        MDR_out = 1'b1; R0_in = 1'b1;
        #1;
        check("bus_mdr", {32'h0, Bus_Data}, 64'h1234);
        tick();
        check("r0_load", {32'h0, R0_Data}, 64'h1234);

        // Fetch T0..T2.
        PC_out = 1'b1; MAR_in = 1'b1; Z_in = 1'b1; alu_instruction = 5'b00000;
        tick();
        check("t0_mar",  {32'h0, MAR_Data}, 64'h0);
        check("t0_zlow", {32'h0, Zlow_Data}, 64'h1);
        check("t0_zhi",  {32'h0, Zhigh_Data}, 64'h0);
        Zlow_out = 1'b1; PC_in = 1'b1; Read = 1'b1; MDR_in = 1'b1; Mdatain = 32'h8808_0000;
        tick();
        check("t1_pc",  {32'h0, PC_Data},  64'h1);
        check("t1_mdr", {32'h0, MDR_Data}, 64'h8808_0000);
        MDR_out = 1'b1; IR_in = 1'b1;
        tick();
        ir_v = 32'h8808_0000;
        check("t2_ir", {32'h0, IR_Data}, {32'h0, ir_v});

        // neg using the opcode field of IR.
        Mdatain = 32'hFFFF_CFC7; Read = 1'b1; MDR_in = 1'b1;
        tick();
        MDR_out = 1'b1; R1_in = 1'b1;
        tick();
        check("r1_load", {32'h0, R1_Data}, 64'hFFFF_CFC7);
        R1_out = 1'b1; Z_in = 1'b1; alu_instruction = ir_v[31:27];
        tick();
        check("neg_z", {Zhigh_Data, Zlow_Data}, 64'h3039);
        Zlow_out = 1'b1; R0_in = 1'b1;
        tick();
        check("neg_r0", {32'h0, R0_Data}, 64'h3039);

        // Bus priority: MDR=FFFFCFC7 Zlow=3039 PC=1 R1=FFFFCFC7 R0=3039.
        MDR_out = 1'b1; Zlow_out = 1'b1; PC_out = 1'b1; R1_out = 1'b1; R0_out = 1'b1;
        #1; check("prio_mdr", {32'h0, Bus_Data}, 64'hFFFF_CFC7);
        MDR_out = 1'b0;
        #1; check("prio_zlow", {32'h0, Bus_Data}, 64'h3039);
        Zlow_out = 1'b0;
        #1; check("prio_pc", {32'h0, Bus_Data}, 64'h1);
        PC_out = 1'b0;
        #1; check("prio_r1", {32'h0, Bus_Data}, 64'hFFFF_CFC7);
        R1_out = 1'b0; R0_in = 1'b1; Z_in = 1'b1;
        #1; check("prio_r0", {32'h0, Bus_Data}, 64'h3039);
        R0_out = 1'b0;
        #1; check("bus_idle", {32'h0, Bus_Data}, 64'h0);
        tick();
        check("idle_r0", {32'h0, R0_Data}, 64'h0);
        check("idle_inc", {Zhigh_Data, Zlow_Data}, 64'h1);

        // Wrap-around add/sub.
        load_y(32'hFFFF_FFFF);
        check("y_load", {32'h0, Y_Data}, 64'hFFFF_FFFF);
        alu_mdr(5'b00011, 32'h1);
        check("add_wrap", {Zhigh_Data, Zlow_Data}, 64'h0);
        load_y(32'h0);
        alu_mdr(5'b00100, 32'h1);
        check("sub_wrap", {Zhigh_Data, Zlow_Data}, 64'h0000_0000_FFFF_FFFF);

        // Shifts.
        load_y(32'h8000_0001);
        alu_mdr(5'b01000, 32'h1);
        check("shra", {Zhigh_Data, Zlow_Data}, 64'hC000_0000);
        alu_mdr(5'b01010, 32'h1);
        check("ror", {Zhigh_Data, Zlow_Data}, 64'hC000_0000);
        alu_mdr(5'b01001, 32'h1);
        check("shl", {Zhigh_Data, Zlow_Data}, 64'h2);
        alu_mdr(5'b00111, 32'h0);
        check("shr0", {Zhigh_Data, Zlow_Data}, 64'h8000_0001);

        // Multiply/divide or their increment fallback.
        load_y(32'hFFFF_FFFA);
`ifdef DATAPATH_MULDIV_EN
        alu_mdr(5'b01111, 32'h4);
        check("mul", {Zhigh_Data, Zlow_Data}, 64'hFFFF_FFFF_FFFF_FFE8);
        alu_mdr(5'b10000, 32'h4);
        check("div", {Zhigh_Data, Zlow_Data}, 64'hFFFF_FFFE_FFFF_FFFF);
        alu_mdr(5'b10000, 32'h0);
        check("div0", {Zhigh_Data, Zlow_Data}, 64'hFFFF_FFFA_FFFF_FFFF);
`else
        alu_mdr(5'b01111, 32'h4);
        check("mul_off", {Zhigh_Data, Zlow_Data}, 64'h5);
        alu_mdr(5'b10000, 32'h4);
        check("div_off", {Zhigh_Data, Zlow_Data}, 64'h5);
`endif

        // Randomized operands and opcodes against the reference model.
        for (int it = 0; it < 40; it++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'h0;
                1:       b = $urandom_range(0, 40);
                default: b = $urandom;
            endcase
            op = 5'($urandom_range(0, 31));
            if (it % 3 == 0) op = 5'($urandom_range(3, 18));
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'h3;
            load_y(a);
            check("rnd_y", {32'h0, Y_Data}, {32'h0, a});
            alu_mdr(op, b);
            check($sformatf("rnd_op%0d", op), {Zhigh_Data, Zlow_Data}, ref_alu(op, a, b));
        end

        // Mid-run reset clears immediately and holds against load enables.
        MDR_in = 1'b1; Read = 1'b1; Mdatain = 32'hDEAD_BEEF;
        tick();
        PC_out = 1'b1; PC_in = 1'b1; Z_in = 1'b1;
        #3;
        clr = 1'b0;
        #1;
        check_all_zero("rst_mid");
        Read = 1'b1; MDR_in = 1'b1; Mdatain = 32'h5555_AAAA; R0_in = 1'b1;
        @(posedge clk);
        #1;
        check("rst_hold_mdr", {32'h0, MDR_Data}, 64'h0);
        all_off();
        @(negedge clk);
        clr = 1'b1;
        #1;
        check("rst_pc", {32'h0, PC_Data}, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
